spi_byte_engine: RTL and testbench
==================================

// Module: spi_byte_engine
// PURPOSE
//  Hardware SPI byte shifter behind the extension's ctrl-code decoder (extended device 0xc).
//  Replaces bit-banged SCK/MOSI toggling: one ctrl write starts an 8-bit mode-0 transfer.
//  Received byte and status are returned to the GBUS read mux in place of the bit-banged MISO bit.
//  Drives the same MOSI/SCK/nSS pins as the bit-bang path; top level muxes on busy.
// PARAMETERS
//  DIV_W   4   width of half-period divider; half SCK period = (div+1) CLKx4 cycles
//  NSS     2   number of active-low slave selects driven (MISO has NSS+1 inputs)
// PORTS
//  CLKx4     in   1      block clock (4x Gigatron clock)
//  RST       in   1      asynchronous, active-high reset
//  wr_data   in   1      1-cycle strobe: start transfer with tx_byte
//  tx_byte   in   8      byte to send (GAH[15:8] at ctrl write)
//  wr_cfg    in   1      1-cycle strobe: load cfg_div and cfg_ss
//  cfg_div   in   DIV_W  half-period divider value
//  cfg_ss    in   NSS    active-low select pattern to drive on nSS
//  MISO      in   NSS+1  slave data inputs; MISO[NSS] is the default (no select) line
//  MOSI      out  1      serial data out, MSB first
//  SCK       out  1      serial clock, idle low
//  nSS       out  NSS    slave selects, active low
//  rx_byte   out  8      last received byte
//  busy      out  1      transfer in progress
//  done      out  1      1-cycle pulse when rx_byte updated
//  ovr       out  1      sticky: write/cfg strobe arrived while busy
// BEHAVIOUR
//  Reset: MOSI=0, SCK=0, nSS=all 1, rx_byte=0x00, busy=0, done=0, ovr=0, div=0, state IDLE.
//  Mode 0 (CPOL=0, CPHA=0), MSB first. Effective miso = OR over i<NSS of (MISO[i] & !nSS[i])
//   | (MISO[NSS] & all nSS high).
//  States: IDLE -> LO (SCK=0) <-> HI (SCK=1) -> IDLE; 3-bit bit counter, DIV_W-bit half counter.
//  IDLE + wr_data: next edge busy=1, MOSI=tx_byte[7], SCK=0, half counter=div, bit=0, state LO.
//  LO: counter reaches 0 -> SCK=1, sample miso into shift LSB, reload counter, state HI.
//  HI: counter reaches 0 -> SCK=0; if bit==7: rx_byte<=shift, busy=0, done=1, MOSI holds
//   last bit, state IDLE; else MOSI<=next bit, bit+=1, reload, state LO.
//  Latency: accept edge to busy low = 16*(div+1) cycles; div=0 -> 16 cycles, SCK 8 pulses
//   each 1 cycle high / 1 cycle low.
//  wr_data or wr_cfg while busy: ignored (no effect on transfer/div/nSS), ovr<=1.
//  wr_data and wr_cfg same cycle while IDLE: cfg applied first; transfer uses new div/nSS.
//  ovr cleared only by an accepted wr_cfg (idle) or RST.
//  done and a new wr_data in the same cycle: accepted (state is IDLE on that edge's input? no:
//   done cycle state is IDLE, so wr_data in the done cycle is accepted next edge).
//  cfg_div latched internally; changes on cfg_div pins without wr_cfg have no effect.
//  RST mid-transfer: immediate abort to reset values; rx_byte not updated from partial shift.
//  nSS changes only via wr_cfg; engine never toggles nSS itself (software frames transfers).
// STRUCTURE
//  Shared package gigatron_ext_pkg: state enum {IDLE,LO,HI}, DEV_SPI=4'hc, DIV_W default.
//  Sub-module spi_half_div: loadable down-counter with terminal-count pulse (reload, tc).
//  Remainder (FSM, shift registers, miso mux, flags) stays in spi_byte_engine.
// TESTING
//  div=0, cfg_ss=2'b10, MISO[0] looped to MOSI, tx 0xA5 -> 8 SCK pulses, done at +16, rx 0xA5.
//  div=3, MISO[2]=1, cfg_ss=2'b11, tx 0x3C -> SCK high 4 cyc, busy 64 cyc, rx 0xFF, MOSI 00111100.
//  wr_data 0x11 at cycle 5 of active 0xA5 transfer -> ignored, ovr=1, rx 0xA5; wr_cfg idle clears ovr.
//  wr_cfg div=7 while busy -> ovr=1, running transfer keeps div=0 timing, next transfer div=0.
//  RST at 3rd SCK high -> SCK=0, nSS=11, busy=0, rx_byte=0x00; next 0x5A transfer completes ok.
//  wr_data in done cycle (back-to-back) -> second transfer starts next edge, no SCK glitch.

Source files
------------

// File: rtl/gigatron_ext_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gigatron_ext_pkg: shared constants and types for the extension devices. Rev 1.0
// ----------------------------------------------------------------------------
package gigatron_ext_pkg;
  localparam logic [3:0] DEV_SPI       = 4'hc;
  localparam int         DIV_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } spi_state_e;
endpackage
`default_nettype wire

// File: rtl/spi_half_div.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_half_div: loadable down-counter, tc high while the count sits at zero. Rev 1.0
// ----------------------------------------------------------------------------
module spi_half_div
  import gigatron_ext_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_byte_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_byte_engine: mode-0 MSB-first SPI byte shifter for extended device 0xc. Rev 1.0
// ----------------------------------------------------------------------------
module spi_byte_engine
  import gigatron_ext_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT,
  parameter int NSS   = 2
) (
  input  logic             CLKx4,
  input  logic             RST,
  input  logic             wr_data,
  input  logic [7:0]       tx_byte,
  input  logic             wr_cfg,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [NSS-1:0]   cfg_ss,
  input  logic [NSS:0]     MISO,
  output logic             MOSI,
  output logic             SCK,
  output logic [NSS-1:0]   nSS,
  output logic [7:0]       rx_byte,
  output logic             busy,
  output logic             done,
  output logic             ovr
);

  spi_state_e       state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bit_q, bit_d;
  logic             mosi_q, mosi_d;
  logic             sck_q, sck_d;
  logic [7:0]       rx_q, rx_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [NSS-1:0]   ss_q, ss_d;

  logic             div_load;
  logic [DIV_W-1:0] div_load_val;
  logic             half_tc;
  logic             miso;
  logic [NSS-1:0]   sel_hit;

  spi_half_div #(.DIV_W(DIV_W)) u_half_div (
    .clk      (CLKx4),
    .rst      (RST),
    .load     (div_load),
    .load_val (div_load_val),
    .tc       (half_tc)
  );

  for (genvar i = 0; i < NSS; i++) begin : g_miso_sel
    assign sel_hit[i] = MISO[i] & ~ss_q[i];
  end

  // The default line only counts when no slave is selected.
  assign miso = (|sel_hit) | (MISO[NSS] & (&ss_q));
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_d        = bit_q;
    mosi_d       = mosi_q;
    sck_d        = sck_q;
    rx_d         = rx_q;
    done_d       = 1'b0;
    ovr_d        = ovr_q;
    div_d        = div_q;
    ss_d         = ss_q;
    div_load     = 1'b0;
    div_load_val = div_q;

    case (state_q)
      IDLE: begin
        if (wr_cfg) begin
          div_d = cfg_div;
          ss_d  = cfg_ss;
          ovr_d = 1'b0;
        end
        if (wr_data) begin
          state_d      = LO;
          sr_d         = tx_byte;
          bit_d        = 3'd0;
          mosi_d       = tx_byte[7];
          sck_d        = 1'b0;
          div_load     = 1'b1;
          div_load_val = wr_cfg ? cfg_div : div_q;
        end
      end
      LO: begin
        if (half_tc) begin
          state_d  = HI;
          sck_d    = 1'b1;
          sr_d     = {sr_q[6:0], miso};
          div_load = 1'b1;
        end
      end
      HI: begin
        if (half_tc) begin
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = IDLE;
            rx_d    = sr_q;
            done_d  = 1'b1;
          end else begin
            state_d  = LO;
            // After a sample, sr_q[7] holds the next outgoing tx bit.
            mosi_d   = sr_q[7];
            bit_d    = bit_q + 3'd1;
            div_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (busy && (wr_data || wr_cfg)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge CLKx4 or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      mosi_q  <= 1'b0;
      sck_q   <= 1'b0;
      rx_q    <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      div_q   <= '0;
      ss_q    <= '1;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      mosi_q  <= mosi_d;
      sck_q   <= sck_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      div_q   <= div_d;
      ss_q    <= ss_d;
    end
  end

  assign MOSI    = mosi_q;
  assign SCK     = sck_q;
  assign nSS     = ss_q;
  assign rx_byte = rx_q;
  assign done    = done_q;
  assign ovr     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_byte_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_spi_byte_engine: vector table, corner sequences and random transfers. Rev 1.0
// ----------------------------------------------------------------------------
module tb_spi_byte_engine;

  logic       CLKx4   = 1'b0;
  logic       RST     = 1'b1;
  logic       wr_data = 1'b0;
  logic       wr_cfg  = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [3:0] cfg_div = 4'h0;
  logic [1:0] cfg_ss  = 2'b11;
  logic [2:0] MISO    = 3'b000;
  logic       MOSI, SCK, busy, done, ovr;
  logic [1:0] nSS;
  logic [7:0] rx_byte;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] model_div;
  logic [1:0] model_ss;
  logic       model_ovr;
  logic [7:0] sbv [3];
  bit         loop_en;

  typedef struct {
    logic [7:0] tx;
    logic [3:0] div;
    logic [1:0] ss;
    bit         loop;
    bit         same;
    logic [7:0] b0, b1, b2;
    logic [7:0] exp_rx;
    int         exp_cyc;
  } vec_t;

  vec_t vecs [8];

  always #5 CLKx4 = ~CLKx4;

  spi_byte_engine #(.DIV_W(4), .NSS(2)) dut (
    .CLKx4   (CLKx4),
    .RST     (RST),
    .wr_data (wr_data),
    .tx_byte (tx_byte),
    .wr_cfg  (wr_cfg),
    .cfg_div (cfg_div),
    .cfg_ss  (cfg_ss),
    .MISO    (MISO),
    .MOSI    (MOSI),
    .SCK     (SCK),
    .nSS     (nSS),
    .rx_byte (rx_byte),
    .busy    (busy),
    .done    (done),
    .ovr     (ovr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Received byte a master sees: OR of every selected slave, default line when none.
  function automatic logic [7:0] model_rx(input logic [1:0] ss, input logic [7:0] b0,
                                          input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] r;
    r = 8'h00;
    if (!ss[0]) r = r | b0;
    if (!ss[1]) r = r | b1;
    if (ss == 2'b11) r = r | b2;
    return r;
  endfunction

  // Each slave presents bit 7-k of its byte during bit k (shifts on SCK falling).
  task automatic drive_miso(input int k);
    for (int i = 0; i < 3; i++) begin
      MISO[i] = (k < 8) ? sbv[i][7-k] : 1'b0;
    end
    if (loop_en) MISO[0] = MOSI;
  endtask

  task automatic cfg(input logic [3:0] d, input logic [1:0] s);
    cfg_div = d;
    cfg_ss  = s;
    wr_cfg  = 1'b1;
    @(negedge CLKx4);
    wr_cfg    = 1'b0;
    model_div = d;
    model_ss  = s;
    model_ovr = 1'b0;
  endtask

  // Starts a transfer at the current negedge and returns at the negedge showing done.
  task automatic xfer(input logic [7:0] tx, input bit with_cfg, input int inj_c,
                      input bit inj_cfg, input logic [7:0] exp_rx, input int exp_cyc);
    int         n, k, pulses, hi_w, hi_max, hi_sum, spur;
    logic [7:0] cap;
    logic       prev;
    bit         fin;
    n = 0; k = 0; pulses = 0; hi_w = 0; hi_max = 0; hi_sum = 0; spur = 0;
    cap = 8'h00; prev = 1'b0; fin = 1'b0;
    tx_byte = tx;
    wr_data = 1'b1;
    if (with_cfg) begin
      wr_cfg    = 1'b1;
      cfg_div   = model_div;
      cfg_ss    = model_ss;
      model_ovr = 1'b0;
    end
    drive_miso(0);
    for (int c = 1; c <= 16 * 17 + 8 && !fin; c++) begin
      @(negedge CLKx4);
      wr_data = 1'b0;
      wr_cfg  = 1'b0;
      cfg_div = ~model_div;
      if (SCK && !prev) begin
        cap = {cap[6:0], MOSI};
        pulses++;
        hi_w = 0;
      end
      if (SCK) begin
        hi_w++;
        hi_sum++;
        if (hi_w > hi_max) hi_max = hi_w;
      end
      if (!SCK && prev) k++;
      prev = SCK;
      if (busy) begin
        n++;
        if (done) spur++;
        drive_miso(k);
        if (c == inj_c) begin
          if (inj_cfg) begin
            wr_cfg  = 1'b1;
            cfg_div = 4'd7;
            cfg_ss  = ~model_ss;
          end else begin
            wr_data = 1'b1;
            tx_byte = 8'h11;
          end
          model_ovr = 1'b1;
        end
      end else begin
        fin = 1'b1;
      end
    end
    check("busy_end",   32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("busy_cycles", 32'(n), 32'(exp_cyc));
    check("sck_pulses", 32'(pulses), 32'd8);
    check("mosi_bits",  32'(cap), 32'(tx));
    check("sck_hi_sum", 32'(hi_sum), 32'(8 * (int'(model_div) + 1)));
    check("sck_hi_max", 32'(hi_max), 32'(int'(model_div) + 1));
    check("done_early", 32'(spur), 32'd0);
    check("rx_byte",    32'(rx_byte), 32'(exp_rx));
    check("nss",        32'(nSS), 32'(model_ss));
    check("ovr",        32'(ovr), 32'(model_ovr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    model_div = 4'd0;
    model_ss  = 2'b11;
    model_ovr = 1'b0;
    loop_en   = 1'b0;
    sbv       = '{default: 8'h00};

    vecs[0] = '{8'hA5, 4'd0,  2'b10, 1, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 16};
    vecs[1] = '{8'h3C, 4'd3,  2'b11, 0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 64};
    vecs[2] = '{8'h69, 4'd1,  2'b01, 0, 0, 8'hFF, 8'h96, 8'hFF, 8'h96, 32};
    vecs[3] = '{8'h0F, 4'd0,  2'b00, 0, 1, 8'h81, 8'h18, 8'hFF, 8'h99, 16};
    vecs[4] = '{8'hC3, 4'd15, 2'b11, 0, 0, 8'hFF, 8'hFF, 8'h5A, 8'h5A, 256};
    vecs[5] = '{8'h00, 4'd2,  2'b10, 0, 1, 8'hC0, 8'h3F, 8'hFF, 8'hC0, 48};
    vecs[6] = '{8'hFF, 4'd0,  2'b01, 1, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 16};
    vecs[7] = '{8'h5A, 4'd1,  2'b11, 0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 32};

    repeat (3) @(posedge CLKx4);
    @(negedge CLKx4);
    RST = 1'b0;
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_sck",  32'(SCK), 32'd0);
    check("rst_nss",  32'(nSS), 32'd3);
    check("rst_rx",   32'(rx_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovr",  32'(ovr), 32'd0);

    foreach (vecs[i]) begin
      loop_en = vecs[i].loop;
      sbv[0]  = vecs[i].b0;
      sbv[1]  = vecs[i].b1;
      sbv[2]  = vecs[i].b2;
      if (vecs[i].same) begin
        model_div = vecs[i].div;
        model_ss  = vecs[i].ss;
        xfer(vecs[i].tx, 1, 0, 0, vecs[i].exp_rx, vecs[i].exp_cyc);
      end else begin
        cfg(vecs[i].div, vecs[i].ss);
        xfer(vecs[i].tx, 0, 0, 0, vecs[i].exp_rx, vecs[i].exp_cyc);
      end
    end

    // Overrun by data strobe, then by cfg strobe; ovr sticks until an idle cfg.
    loop_en = 1'b1;
    cfg(4'd0, 2'b10);
    xfer(8'hA5, 0, 5, 0, 8'hA5, 16);
    cfg(4'd0, 2'b10);
    check("ovr_cleared", 32'(ovr), 32'd0);
    xfer(8'hA5, 0, 5, 1, 8'hA5, 16);
    xfer(8'h3C, 0, 0, 0, 8'h3C, 16);
    cfg(4'd0, 2'b10);

    // Asynchronous reset during the third SCK high phase.
    tx_byte = 8'hC3;
    wr_data = 1'b1;
    rises   = 0;
    for (int c = 0; c < 100 && rises < 3; c++) begin
      @(negedge CLKx4);
      wr_data = 1'b0;
      if (SCK && dut.busy) begin
        if (c == 0 || rises == 0 || !MISO[1]) rises++;
        MISO[1] = 1'b1;
      end else begin
        MISO[1] = 1'b0;
      end
    end
    check("abort_reached", 32'(rises), 32'd3);
    RST = 1'b1;
    #1;
    check("abort_sck",  32'(SCK), 32'd0);
    check("abort_mosi", 32'(MOSI), 32'd0);
    check("abort_nss",  32'(nSS), 32'd3);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx",   32'(rx_byte), 32'd0);
    @(negedge CLKx4);
    RST       = 1'b0;
    model_div = 4'd0;
    model_ss  = 2'b11;
    model_ovr = 1'b0;
    cfg(4'd0, 2'b10);
    xfer(8'h5A, 0, 0, 0, 8'h5A, 16);

    // Back-to-back: second strobe lands in the done cycle.
    xfer(8'h3C, 0, 0, 0, 8'h3C, 16);
    xfer(8'hC3, 0, 0, 0, 8'hC3, 16);

    loop_en = 1'b0;
    for (int r = 0; r < 24; r++) begin
      logic [3:0] d;
      logic [1:0] s;
      logic [7:0] tx;
      bit         same;
      d    = 4'($urandom_range(0, 3));
      s    = 2'($urandom_range(0, 3));
      tx   = 8'($urandom);
      same = bit'($urandom_range(0, 1));
      for (int i = 0; i < 3; i++) sbv[i] = 8'($urandom);
      if (same) begin
        model_div = d;
        model_ss  = s;
        xfer(tx, 1, 0, 0, model_rx(s, sbv[0], sbv[1], sbv[2]), 16 * (int'(d) + 1));
      end else begin
        cfg(d, s);
        xfer(tx, 0, 0, 0, model_rx(s, sbv[0], sbv[1], sbv[2]), 16 * (int'(d) + 1));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
